csi2_rx_pkt_parser: RTL
=======================

// Module: csi2_rx_pkt_parser
// PURPOSE
//  Upstream neighbour of the byte-to-pixel stage, in the clk_byte domain. Takes lane-merged
//  CSI-2 HS bytes and parses header -> payload -> end of burst. Emits sp_en/dt/lp_av_en/wc
//  and payload_en/payload in the exact form the byte-to-pixel stage consumes.
// PARAMETERS
//  NUM_RX_LANE  4  bytes per cycle B (legal: 1,2,4); RX_GEAR fixed at 8
//  AV_DT_LO     6'h18  lowest data type treated as active video (inclusive)
//  AV_DT_HI     6'h37  highest data type treated as active video (inclusive)
// PORTS
//  clk_byte_i    in   1      byte clock
//  reset_byte_i  in   1      synchronous, active-high reset
//  hs_valid_i    in   1      high for the whole HS burst, contiguous; fall = end of burst
//  hs_data_i     in   8*B    byte k at [8k+7:8k]; earliest byte in byte 0
//  sp_en_o       out  1      1-cycle pulse: short packet decoded (DT 0x00-0x0F)
//  lp_av_en_o    out  1      1-cycle pulse: long active-video packet header decoded
//  dt_o          out  6      DT of last accepted header; held
//  vc_o          out  2      VC of last accepted header; held
//  wc_o          out  16     WC (long) or data field (short); held
//  payload_en_o  out  1      payload word valid
//  payload_o     out  8*B    payload word, same byte order as hs_data_i
//  trunc_err_o   out  1      1-cycle pulse: burst ended before WC bytes were delivered
//  ecc_err_o     out  1      1-cycle pulse: header ECC mismatch (0 without ECC_CHECK_EN)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, byte counters 0. Reset wins over any event in the same cycle.
//  FSM:
//  - IDLE: hs_valid_i rise -> HDR; the first word is header byte 0..B-1.
//  - HDR: collects 4 header bytes in 4/B cycles (B=4: 1 cycle).
//    Byte0 = {VC[7:6], DT[5:0]}; byte1 = WC LSB; byte2 = WC MSB; byte3 = ECC.
//  - Header complete in cycle N: outputs are registered and update at N+1.
//    - DT < 0x10: sp_en_o pulse -> WAIT_END.
//    - DT >= 0x10 and wc = 0: lp_av_en_o pulse if AV -> WAIT_END.
//    - DT >= 0x10 and wc > 0: lp_av_en_o pulse if AV -> PAYLOAD; rem = wc.
//  - PAYLOAD: each valid cycle, rem -= B; saturate at 0. The word containing the last payload
//    byte is the final beat; 16-bit arithmetic, no wrap. Final beat -> WAIT_END.
//    - AV DT: payload_en_o=1, payload_o=word, both registered 1 cycle after the input word.
//    - Non-AV DT (e.g. 0x12 embedded): bytes consumed, payload_en_o stays 0.
//    - Beats per packet = ceil(wc/B). CRC and filler bytes in or after the final word are
//      ignored; the consumer trims using wc_o.
//  - WAIT_END: ignore data until hs_valid_i=0 -> IDLE. One packet per HS burst.
//  hs_valid_i falls in HDR: header discarded, no pulses, -> IDLE.
//  hs_valid_i falls in PAYLOAD before the final beat: no more payload_en_o.
//    trunc_err_o pulses 1 cycle after the fall; -> IDLE.
//  dt_o/vc_o/wc_o change only on an accepted header; never mid-payload.
//  No backpressure: the downstream stage always accepts payload_en_o words.
// CONFIGURATION
//  ECC_CHECK_EN defined:
//  - Compute MIPI 6-bit Hamming ECC over header bytes 0-2; compare with byte3[5:0].
//  - Mismatch: ecc_err_o pulses at N+1; no sp_en/lp_av_en; held fields unchanged; -> WAIT_END.
//  - Detection only, no single-bit correction.
//  ECC_CHECK_EN undefined: byte3 ignored; ecc_err_o tied 0; no ECC logic synthesised.
// STRUCTURE
//  csi2_rx_pkg:
//  - FSM state enum {IDLE,HDR,PAYLOAD,WAIT_END}
//  - DT class constants: SP_DT_MAX=6'h0F, LP_DT_MIN=6'h10
//  - ECC parity-matrix function
//  Sub-module csi2_ecc_calc: combinational, 24-bit header in, 6-bit ECC out; instantiated
//  only under ECC_CHECK_EN.
// TESTING
//  B=4: Frame Start header bytes {00,01,00,ecc}
//   -> sp_en_o pulse at N+1; dt_o=00, wc_o=0001; no payload_en_o.
//  B=4: RAW10 {2B,0A,00,ecc}, then 3 data words
//   -> lp_av_en_o pulse; payload_en_o for 3 cycles, 1-cycle lag; wc_o=000A.
//  B=2: same RAW10 packet
//   -> header over 2 cycles; payload_en_o for 5 cycles; data bytes identical in order.
//  DT=12, wc=8 (embedded), B=4
//   -> no lp_av_en_o, no payload_en_o; IDLE after hs_valid_i falls; dt_o=12.
//  wc=0 RAW10 packet
//   -> lp_av_en_o pulse, zero payload_en_o.
//  hs_valid_i drops after beat 1 of 3
//   -> exactly 1 payload_en_o cycle, trunc_err_o pulse; next burst parses normally.
//  ECC_CHECK_EN, header bit 3 flipped
//   -> ecc_err_o pulse, no sp_en_o/lp_av_en_o; undefined macro: same header is accepted.
//  reset_byte_i for 1 cycle mid-payload
//   -> all outputs 0 next cycle; FSM IDLE; next burst is clean.

Source files
------------

// File: rtl/csi2_rx_pkg.sv
// Shared types and constants for the CSI-2 RX packet parser.
//  - state_t   : parser FSM states
//  - SP_DT_MAX : highest short-packet data type
//  - LP_DT_MIN : lowest long-packet data type
//  - ecc_calc  : MIPI 6-bit Hamming ECC over the 24-bit header, where
//                bit 0 is header byte 0 bit 0
package csi2_rx_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, WAIT_END} state_t;

  localparam logic [5:0] SP_DT_MAX = 6'h0F;
  localparam logic [5:0] LP_DT_MIN = 6'h10;

  // Each row selects the header bits that feed one parity bit (P5..P0).
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
  };

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    for (int i = 0; i < 6; i++) p[i] = ^(d & ECC_MASK[i]);
    return p;
  endfunction

endpackage

// File: rtl/csi2_rx_pkt_parser_if.sv
// Bus bundle between the lane merger, the packet parser and the
// byte-to-pixel stage.
//  hs_valid_i/hs_data_i : merged HS byte stream into the parser
//  sp_en_o .. ecc_err_o : decoded header fields, payload and error pulses
// modport master : the side that drives HS bytes and consumes the results
// modport slave  : the parser
interface csi2_rx_pkt_parser_if #(
  parameter int NUM_RX_LANE = 4
);
  logic                     hs_valid_i;
  logic [8*NUM_RX_LANE-1:0] hs_data_i;
  logic                     sp_en_o;
  logic                     lp_av_en_o;
  logic [5:0]               dt_o;
  logic [1:0]               vc_o;
  logic [15:0]              wc_o;
  logic                     payload_en_o;
  logic [8*NUM_RX_LANE-1:0] payload_o;
  logic                     trunc_err_o;
  logic                     ecc_err_o;

  modport master (
    output hs_valid_i, hs_data_i,
    input  sp_en_o, lp_av_en_o, dt_o, vc_o, wc_o, payload_en_o, payload_o,
           trunc_err_o, ecc_err_o
  );

  modport slave (
    input  hs_valid_i, hs_data_i,
    output sp_en_o, lp_av_en_o, dt_o, vc_o, wc_o, payload_en_o, payload_o,
           trunc_err_o, ecc_err_o
  );
endinterface

// File: rtl/csi2_ecc_calc.sv
// Combinational CSI-2 packet-header ECC generator.
//  hdr : header bytes {byte2, byte1, byte0}
//  ecc : expected ECC (compare against byte3[5:0])
module csi2_ecc_calc
  import csi2_rx_pkg::*;
(
  input  logic [23:0] hdr,
  output logic [5:0]  ecc
);
  assign ecc = ecc_calc(hdr);
endmodule

// File: rtl/csi2_rx_pkt_parser.sv
// CSI-2 RX packet parser (clk_byte domain).
// Splits one HS burst into header -> payload -> end of burst and presents
// header fields and payload words to the byte-to-pixel stage.
// Ports:
//  clk_byte_i   : byte clock
//  reset_byte_i : synchronous active-high reset
//  rx (slave)   : hs_valid_i/hs_data_i in; sp_en_o, lp_av_en_o, dt_o, vc_o,
//                 wc_o, payload_en_o, payload_o, trunc_err_o, ecc_err_o out
// Build option: define ECC_CHECK_EN to check the header ECC; otherwise
// byte 3 is ignored and ecc_err_o is tied 0.
module csi2_rx_pkt_parser
  import csi2_rx_pkg::*;
#(
  parameter int         NUM_RX_LANE = 4,
  parameter logic [5:0] AV_DT_LO    = 6'h18,
  parameter logic [5:0] AV_DT_HI    = 6'h37
) (
  input logic                 clk_byte_i,
  input logic                 reset_byte_i,
  csi2_rx_pkt_parser_if.slave rx
);
  localparam int B = NUM_RX_LANE;

  state_t             state, state_d;
  logic [1:0]         hdr_cnt, hdr_cnt_d;
  logic [3:0][7:0]    hdr_buf, hdr_buf_d, hdr_now;
  logic [15:0]        rem, rem_d;
  logic               av_pkt, av_pkt_d;
  logic               vld_q;
  logic [B-1:0][7:0]  word;

  logic               sp_q, sp_d, lp_q, lp_d, pe_q, pe_d;
  logic               trunc_q, trunc_d, ecc_q, ecc_d;
  logic [5:0]         dt_q, dt_d;
  logic [1:0]         vc_q, vc_d;
  logic [15:0]        wc_q, wc_d;
  logic [8*B-1:0]     pl_q, pl_d;

  logic               hs_start, hdr_done, take_hdr, is_av, ecc_bad;
  logic [5:0]         dt_w;
  logic [15:0]        wc_w;
  logic               byte3_unused;

  assign word     = rx.hs_data_i;
  // Only a real rising edge starts a packet, so a burst interrupted by a
  // reset is ignored until hs_valid_i has dropped.
  assign hs_start = rx.hs_valid_i && !vld_q;
  assign hdr_done = ({1'b0, hdr_cnt} + 3'(B)) == 3'd4;

  // Header as it will look once this cycle's word is merged in.
  always_comb begin
    hdr_now = hdr_buf;
    for (int k = 0; k < B; k++) hdr_now[2'(int'(hdr_cnt) + k)] = word[k];
  end

  assign dt_w  = hdr_now[0][5:0];
  assign wc_w  = {hdr_now[2], hdr_now[1]};
  assign is_av = (dt_w >= AV_DT_LO) && (dt_w <= AV_DT_HI);

`ifdef ECC_CHECK_EN
  logic [5:0] ecc_exp;
  csi2_ecc_calc u_ecc (
    .hdr ({hdr_now[2], hdr_now[1], hdr_now[0]}),
    .ecc (ecc_exp)
  );
  assign ecc_bad      = ecc_exp != hdr_now[3][5:0];
  assign byte3_unused = ^hdr_now[3][7:6];
`else
  assign ecc_bad      = 1'b0;
  assign byte3_unused = ^hdr_now[3];
`endif

  always_comb begin
    state_d   = state;
    hdr_cnt_d = hdr_cnt;
    hdr_buf_d = hdr_buf;
    rem_d     = rem;
    av_pkt_d  = av_pkt;
    take_hdr  = 1'b0;
    sp_d      = 1'b0;
    lp_d      = 1'b0;
    pe_d      = 1'b0;
    trunc_d   = 1'b0;
    ecc_d     = 1'b0;
    dt_d      = dt_q;
    vc_d      = vc_q;
    wc_d      = wc_q;
    pl_d      = pl_q;

    case (state)
      IDLE: begin
        hdr_cnt_d = 2'd0;
        take_hdr  = hs_start;
      end
      HDR: begin
        if (!rx.hs_valid_i) begin
          state_d   = IDLE;
          hdr_cnt_d = 2'd0;
        end else begin
          take_hdr = 1'b1;
        end
      end
      PAYLOAD: begin
        if (!rx.hs_valid_i) begin
          trunc_d = 1'b1;
          state_d = IDLE;
        end else begin
          pe_d = av_pkt;
          if (av_pkt) pl_d = rx.hs_data_i;
          if (rem <= 16'(B)) begin
            rem_d   = 16'd0;
            state_d = WAIT_END;
          end else begin
            rem_d = rem - 16'(B);
          end
        end
      end
      WAIT_END: if (!rx.hs_valid_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (take_hdr) begin
      if (!hdr_done) begin
        state_d   = HDR;
        hdr_cnt_d = hdr_cnt + 2'(B);
        hdr_buf_d = hdr_now;
      end else begin
        hdr_cnt_d = 2'd0;
        state_d   = WAIT_END;
        if (ecc_bad) begin
          ecc_d = 1'b1;
        end else begin
          dt_d = dt_w;
          vc_d = hdr_now[0][7:6];
          wc_d = wc_w;
          if (dt_w <= SP_DT_MAX) begin
            sp_d = 1'b1;
          end else begin
            lp_d     = is_av;
            av_pkt_d = is_av;
            rem_d    = wc_w;
            if (wc_w != 16'd0) state_d = PAYLOAD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_byte_i) begin
    if (reset_byte_i) begin
      state   <= IDLE;
      hdr_cnt <= '0;
      hdr_buf <= '0;
      rem     <= '0;
      av_pkt  <= 1'b0;
      sp_q    <= 1'b0;
      lp_q    <= 1'b0;
      pe_q    <= 1'b0;
      trunc_q <= 1'b0;
      ecc_q   <= 1'b0;
      dt_q    <= '0;
      vc_q    <= '0;
      wc_q    <= '0;
      pl_q    <= '0;
    end else begin
      state   <= state_d;
      hdr_cnt <= hdr_cnt_d;
      hdr_buf <= hdr_buf_d;
      rem     <= rem_d;
      av_pkt  <= av_pkt_d;
      sp_q    <= sp_d;
      lp_q    <= lp_d;
      pe_q    <= pe_d;
      trunc_q <= trunc_d;
      ecc_q   <= ecc_d;
      dt_q    <= dt_d;
      vc_q    <= vc_d;
      wc_q    <= wc_d;
      pl_q    <= pl_d;
    end
  end

  // Tracks the line level even during reset (see hs_start).
  always_ff @(posedge clk_byte_i) vld_q <= rx.hs_valid_i;

  assign rx.sp_en_o      = sp_q;
  assign rx.lp_av_en_o   = lp_q;
  assign rx.dt_o         = dt_q;
  assign rx.vc_o         = vc_q;
  assign rx.wc_o         = wc_q;
  assign rx.payload_en_o = pe_q;
  assign rx.payload_o    = pl_q;
  assign rx.trunc_err_o  = trunc_q;
  assign rx.ecc_err_o    = ecc_q;

endmodule
